// File: rtl/brisc_v_run_monitor_pkg.sv
// ============================================================================
// Module   : brisc_v_run_monitor_pkg
// Purpose  : Shared state encoding and sizing helper for the BRISC-V run monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package brisc_v_run_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    // A single halt slot still needs a one-bit index port.
    function automatic int halt_index_width(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/brisc_v_sat_counter.sv
// ============================================================================
// Module   : brisc_v_sat_counter
// Purpose  : Up-counter with synchronous clear that holds at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module brisc_v_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/brisc_v_run_monitor.sv
// ============================================================================
// Module   : brisc_v_run_monitor
// Purpose  : Halt-PC detector, run-cycle counter and end-of-test pass/fail check.
//            Optional run timeout enabled by defining RUN_MONITOR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module brisc_v_run_monitor
    import brisc_v_run_monitor_pkg::*;
#(
    parameter int ADDRESS_BITS   = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_HALT_PCS   = 2,
    parameter int CYCLE_BITS     = 32,
    parameter int DRAIN_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           start,
    input  logic [ADDRESS_BITS-1:0]                        pc,
    input  logic [NUM_HALT_PCS*ADDRESS_BITS-1:0]           halt_pcs,
    input  logic [NUM_HALT_PCS-1:0]                        halt_valid,
    input  logic [DATA_WIDTH-1:0]                          check_value,
    input  logic [DATA_WIDTH-1:0]                          expected_value,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           pass,
    output logic                                           fail,
    output logic                                           timeout,
    output logic [halt_index_width(NUM_HALT_PCS)-1:0]      halt_index,
    output logic [CYCLE_BITS-1:0]                          total_cycles
);

    localparam int IDX_BITS = halt_index_width(NUM_HALT_PCS);

    run_state_t            state;
    run_state_t            state_next;
    logic                  cnt_clear;
    logic                  cnt_enable;
    logic [CYCLE_BITS-1:0] count;
    logic [CYCLE_BITS-1:0] count_inc;
    logic                  halt_match;
    logic [IDX_BITS-1:0]   match_index;
    logic                  timeout_hit;
    logic                  drain_last;
    logic                  values_equal;

    brisc_v_sat_counter #(
        .WIDTH (CYCLE_BITS)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (count)
    );

    // Run length including the matching cycle, saturated like the counter.
    assign count_inc    = (&count) ? count : count + 1'b1;
    assign drain_last   = (count == CYCLE_BITS'(DRAIN_CYCLES - 1));
    assign values_equal = (check_value == expected_value);

    // Scan from the top slot down so the lowest matching index is kept.
    always_comb begin
        halt_match  = 1'b0;
        match_index = '0;
        for (int i = NUM_HALT_PCS - 1; i >= 0; i--) begin
            if (halt_valid[i] && (pc == halt_pcs[i*ADDRESS_BITS +: ADDRESS_BITS])) begin
                halt_match  = 1'b1;
                match_index = IDX_BITS'(i);
            end
        end
    end

`ifdef RUN_MONITOR_TIMEOUT_EN
    assign timeout_hit = (count == CYCLE_BITS'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else if (state == RUN && !halt_match && timeout_hit) begin
            timeout <= 1'b1;
        end else if (state == DONE && start) begin
            timeout <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_clear  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_match) begin
                    cnt_clear  = 1'b1;
                    state_next = DRAIN;
                end else if (timeout_hit) begin
                    state_next = DONE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_next = CHECK;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            CHECK: begin
                state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    cnt_clear  = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            halt_index   <= '0;
            total_cycles <= '0;
        end else begin
            busy <= (state_next == RUN) || (state_next == DRAIN);
            done <= (state_next == DONE);
            case (state)
                RUN: begin
                    if (halt_match) begin
                        total_cycles <= count_inc;
                        halt_index   <= match_index;
                    end else if (timeout_hit) begin
                        total_cycles <= CYCLE_BITS'(TIMEOUT_CYCLES);
                        pass         <= 1'b0;
                        fail         <= 1'b1;
                    end
                end
                CHECK: begin
                    pass <= values_equal;
                    fail <= !values_equal;
                end
                DONE: begin
                    if (start) begin
                        pass         <= 1'b0;
                        fail         <= 1'b0;
                        halt_index   <= '0;
                        total_cycles <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_brisc_v_run_monitor.sv
// ============================================================================
// Module   : tb_brisc_v_run_monitor
// Purpose  : Self-checking bench for brisc_v_run_monitor (table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_brisc_v_run_monitor;

    localparam int AB      = 32;
    localparam int DW      = 32;
    localparam int NH      = 2;
    localparam int CB      = 32;
    localparam int DRAIN   = 50;
    localparam int TIMEOUT = 20;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [AB-1:0]   pc = '0;
    logic [NH*AB-1:0] halt_pcs = '0;
    logic [NH-1:0]   halt_valid = '0;
    logic [DW-1:0]   check_value = '0;
    logic [DW-1:0]   expected_value = '0;
    logic            busy, done, pass, fail, timeout;
    logic [0:0]      halt_index;
    logic [CB-1:0]   total_cycles;

    brisc_v_run_monitor #(
        .ADDRESS_BITS   (AB),
        .DATA_WIDTH     (DW),
        .NUM_HALT_PCS   (NH),
        .CYCLE_BITS     (CB),
        .DRAIN_CYCLES   (DRAIN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .pc             (pc),
        .halt_pcs       (halt_pcs),
        .halt_valid     (halt_valid),
        .check_value    (check_value),
        .expected_value (expected_value),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .timeout        (timeout),
        .halt_index     (halt_index),
        .total_cycles   (total_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        string        name;
        logic [63:0]  halts;
        logic [1:0]   valid;
        int           match_edge;   // 0 = never match
        logic [31:0]  match_pc;
        int           decoy_edge;   // 0 = no decoy
        logic [31:0]  decoy_pc;
        logic [31:0]  cv;
        logic [31:0]  ev;
        int           exp_tc;
        int           exp_idx;
        bit           exp_pass;
        bit           exp_to;
    } case_t;

    typedef struct {
        string name;
        int    tc;
        int    idx;
        bit    ps;
        bit    fl;
        bit    to;
        int    done_edge;           // -1 = latency not checked
    } exp_t;

    exp_t  sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] filler(input int e);
        return 32'h0000_1000 + 32'(e) * 32'd4;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, ".busy"},  64'(busy), 64'd0);
        chk({tag, ".done"},  64'(done), 64'd0);
        chk({tag, ".pass"},  64'(pass), 64'd0);
        chk({tag, ".fail"},  64'(fail), 64'd0);
        chk({tag, ".timeout"}, 64'(timeout), 64'd0);
        chk({tag, ".halt_index"}, 64'(halt_index), 64'd0);
        chk({tag, ".total_cycles"}, 64'(total_cycles), 64'd0);
    endtask

    task automatic run_case(input case_t c);
        exp_t x;
        exp_t got_x;
        bit   got;
        int   done_edge;
        x.name = c.name;
        x.tc = c.exp_tc; x.idx = c.exp_idx;
        x.ps = c.exp_pass; x.fl = !c.exp_pass; x.to = c.exp_to;
        x.done_edge = (c.match_edge != 0) ? c.match_edge + DRAIN + 1 : -1;
        sb.push_back(x);

        @(negedge clock);
        halt_pcs = c.halts; halt_valid = c.valid;
        expected_value = c.ev; check_value = ~c.cv;
        pc = filler(0); start = 1'b1;
        @(posedge clock); #1;
        chk({c.name, ".armed_busy"}, 64'(busy), 64'd1);
        chk({c.name, ".armed_clear"}, {59'd0, done, pass, fail, timeout, halt_index}, 64'd0);
        chk({c.name, ".armed_tc"}, 64'(total_cycles), 64'd0);
        @(negedge clock);
        start = 1'b0;
        got = 1'b0; done_edge = 0;
        for (int e = 1; e <= 2000 && !got; e++) begin
            pc = (e == c.match_edge) ? c.match_pc :
                 (e == c.decoy_edge) ? c.decoy_pc : filler(e);
            start = (e == 2 && c.match_edge > 4);
            check_value = (c.match_edge != 0 && e == c.match_edge + DRAIN + 1) ? c.cv : ~c.cv;
            @(posedge clock); #1;
            if (done) begin
                got = 1'b1;
                done_edge = e;
            end
            @(negedge clock);
        end
        start = 1'b0;
        got_x = sb.pop_front();
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL %s.done_wait: done never rose within 2000 cycles", got_x.name);
        end else begin
            chk({got_x.name, ".total_cycles"}, 64'(total_cycles), 64'(got_x.tc));
            chk({got_x.name, ".halt_index"}, 64'(halt_index), 64'(got_x.idx));
            chk({got_x.name, ".pass"}, 64'(pass), 64'(got_x.ps));
            chk({got_x.name, ".fail"}, 64'(fail), 64'(got_x.fl));
            chk({got_x.name, ".timeout"}, 64'(timeout), 64'(got_x.to));
            chk({got_x.name, ".busy"}, 64'(busy), 64'd0);
            if (got_x.done_edge >= 0)
                chk({got_x.name, ".done_edge"}, 64'(done_edge), 64'(got_x.done_edge));
        end
    endtask

    case_t cases[6];

    initial begin
        cases[0] = '{"normal_pass", {32'hB4, 32'hB0}, 2'b11, 37, 32'hB0, 0, 32'h0,
                     32'h10, 32'h10, 37, 0, 1'b1, 1'b0};
        cases[1] = '{"mismatch", {32'hB4, 32'hB0}, 2'b11, 37, 32'hB0, 0, 32'h0,
                     32'h0F, 32'h10, 37, 0, 1'b0, 1'b0};
        cases[2] = '{"masked_slot0", {32'hB0, 32'hB0}, 2'b10, 12, 32'hB0, 0, 32'h0,
                     32'h55, 32'h55, 12, 1, 1'b1, 1'b0};
        cases[3] = '{"masked_ignore", {32'h100, 32'hB0}, 2'b10, 20, 32'h100, 5, 32'hB0,
                     32'h7, 32'h7, 20, 1, 1'b1, 1'b0};
        cases[4] = '{"first_cycle", {32'hB4, 32'hB0}, 2'b11, 1, 32'hB4, 0, 32'h0,
                     32'hA, 32'hB, 1, 1, 1'b0, 1'b0};
        cases[5] = '{"priority_low", {32'hB0, 32'hB0}, 2'b11, 3, 32'hB0, 0, 32'h0,
                     32'h1, 32'h1, 3, 0, 1'b1, 1'b0};

        // Reset state.
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        // Run with no halt match.
        halt_pcs = {32'hB4, 32'hB0}; halt_valid = 2'b11;
`ifdef RUN_MONITOR_TIMEOUT_EN
        begin
            case_t t;
            t = '{"timeout", {32'hB4, 32'hB0}, 2'b11, 0, 32'h0, 0, 32'h0,
                  32'h1, 32'h1, TIMEOUT, 0, 1'b0, 1'b1};
            run_case(t);
        end
`else
        @(negedge clock);
        start = 1'b1; pc = filler(0);
        @(negedge clock);
        start = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            pc = filler(e);
            @(negedge clock);
        end
        chk("nomatch.busy", 64'(busy), 64'd1);
        chk("nomatch.done", 64'(done), 64'd0);
        chk("nomatch.timeout", 64'(timeout), 64'd0);
        chk("nomatch.total_cycles", 64'(total_cycles), 64'd0);
`endif
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Reset while draining.
        @(negedge clock);
        halt_pcs = {32'hB4, 32'hB0}; halt_valid = 2'b11;
        start = 1'b1; pc = filler(0);
        @(negedge clock);
        start = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            pc = (e == 4) ? 32'hB0 : filler(e);
            @(posedge clock); #1;
            if (e == 4) chk("drain_rst.latched_tc", 64'(total_cycles), 64'd4);
            @(negedge clock);
        end
        chk("drain_rst.busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check_all_zero("drain_rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        pc = 32'hB0;
        repeat (3) @(negedge clock);
        chk("drain_rst.idle_busy", 64'(busy), 64'd0);
        chk("drain_rst.idle_tc", 64'(total_cycles), 64'd0);

        // Back-to-back runs re-armed from DONE.
        for (int i = 0; i < 6; i++) begin
            run_case(cases[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
